mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM encodings,
// access size codes and the IO region select.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIfRd = 2'd1,
    StLsRd = 2'd2,
    StLsWr = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Address bits [17:16] == 2'b11 select memory-mapped IO.
  localparam logic [1:0] IoRegionSel = 2'b11;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      SizeByte: len = 3'd1;
      SizeHalf: len = 3'd2;
      SizeWord: len = 3'd4;
      default:  len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IoRegionSel;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and load/store requests onto a byte-wide
// memory bus with one cycle of read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        ls_req_in,
  input  logic        ls_wr_in,
  input  logic [1:0]  ls_size_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_data_in,
  output logic        ls_done_out,
  output logic [31:0] ls_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  cap_cnt_q, cap_cnt_d;
  logic        cap_pend_q, cap_pend_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_data_q, ls_data_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic        last_ls_q, last_ls_d;

  logic [31:0] issue_addr;
  logic [31:0] rd_word;
  logic        if_pend, ls_pend, conflict, grant_ls, grant_if, issuing;

  assign issue_addr = addr_q + 32'(issue_cnt_q);

  // A request still high in its own done cycle is the finished one, not a new one.
  assign if_pend  = if_req_in && !if_done_q && !clear_in;
  assign ls_pend  = ls_req_in && !ls_done_q;
  assign conflict = if_pend && ls_pend;
  assign grant_ls = rdy_in && ls_pend && (!if_pend || !last_ls_q);
  assign grant_if = rdy_in && if_pend && !grant_ls;
  assign issuing  = issue_cnt_q < len_q;

  always_comb begin
    rd_word = rd_buf_q;
    rd_word[{cap_cnt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    cap_pend_d  = 1'b0;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    if_data_d   = if_data_q;
    ls_data_d   = ls_data_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    last_ls_d   = last_ls_q;
    mem_a       = '0;
    mem_wr      = 1'b0;
    mem_dout    = '0;

    unique case (state_q)
      StIdle: begin
        issue_cnt_d = '0;
        cap_cnt_d   = '0;
        rd_buf_d    = '0;
        if (grant_ls) begin
          state_d = ls_wr_in ? StLsWr : StLsRd;
          addr_d  = ls_addr_in;
          len_d   = size_len(ls_size_in);
          wdata_d = ls_data_in;
        end else if (grant_if) begin
          state_d = StIfRd;
          addr_d  = if_addr_in;
          len_d   = 3'd4;
        end
        // Fairness tracks only contested grants.
        if (conflict && rdy_in) begin
          last_ls_d = grant_ls;
        end
      end

      StIfRd, StLsRd: begin
        if (state_q == StIfRd && clear_in) begin
          state_d     = StIdle;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
        end else begin
          // Instruction fetch never drives an IO address onto the bus.
          if (issuing && rdy_in && !(state_q == StIfRd && is_io(issue_addr))) begin
            mem_a = issue_addr;
          end
          // Only bytes issued while we own the bus are counted, so resuming
          // after rdy_in drops restarts at the oldest uncaptured byte.
          if (issuing && rdy_in) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
            cap_pend_d  = 1'b1;
          end
          if (cap_pend_q) begin
            rd_buf_d  = rd_word;
            cap_cnt_d = cap_cnt_q + 3'd1;
            if (cap_cnt_q + 3'd1 == len_q) begin
              state_d     = StIdle;
              issue_cnt_d = '0;
              cap_cnt_d   = '0;
              cap_pend_d  = 1'b0;
              if (state_q == StIfRd) begin
                if_data_d = rd_word;
                if_done_d = 1'b1;
              end else begin
                ls_data_d = rd_word;
                ls_done_d = 1'b1;
              end
            end
          end
        end
      end

      StLsWr: begin
        if (issuing && rdy_in) begin
          mem_a       = issue_addr;
          mem_wr      = 1'b1;
          mem_dout    = wdata_q[{issue_cnt_q[1:0], 3'b000} +: 8];
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q + 3'd1 == len_q) begin
            state_d     = StIdle;
            issue_cnt_d = '0;
            ls_done_d   = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      cap_pend_q  <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_buf_q    <= '0;
      if_data_q   <= '0;
      ls_data_q   <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      last_ls_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_pend_q  <= cap_pend_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      if_data_q   <= if_data_d;
      ls_data_q   <= ls_data_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      last_ls_q   <= last_ls_d;
    end
  end

  assign if_done_out = if_done_q;
  assign if_data_out = if_data_q;
  assign ls_done_out = ls_done_q;
  assign ls_data_out = ls_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [1:0]  ls_size_in;
  logic [31:0] ls_addr_in;
  logic [31:0] ls_data_in;
  logic        ls_done_out;
  logic [31:0] ls_data_out;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .clear_in    (clear_in),
    .if_req_in   (if_req_in),
    .if_addr_in  (if_addr_in),
    .if_done_out (if_done_out),
    .if_data_out (if_data_out),
    .ls_req_in   (ls_req_in),
    .ls_wr_in    (ls_wr_in),
    .ls_size_in  (ls_size_in),
    .ls_addr_in  (ls_addr_in),
    .ls_data_in  (ls_data_in),
    .ls_done_out (ls_done_out),
    .ls_data_out (ls_data_out),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // Sparse RAM: only the addresses the directed tests touch are backed.
  logic [7:0] ram [0:15] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h34, 8'h12, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};

  function automatic int idx(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 0;
      32'h0000_1001: return 1;
      32'h0000_1002: return 2;
      32'h0000_1003: return 3;
      32'h0000_2000: return 4;
      32'h0000_2001: return 5;
      32'h0000_2002: return 6;
      32'h0000_2003: return 7;
      32'h0000_3002: return 8;
      32'h0000_3003: return 9;
      32'h0003_0000: return 10;
      32'hFFFF_FFFE: return 11;
      32'hFFFF_FFFF: return 12;
      32'h0000_0000: return 13;
      32'h0000_0001: return 14;
      default:       return 15;
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (mem_wr) ram[idx(mem_a)] <= mem_dout;
    mem_din <= ram[idx(mem_a)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #3;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_if_done", {31'h0, if_done_out}, 32'h0);
    chk("rst_if_data", if_data_out, 32'h0);
    chk("rst_ls_data", ls_data_out, 32'h0);
    step();
    rst_n_in = 1'b1;
    step();
  endtask

  int pulses;

  initial begin
    rst_n_in   = 1'b1;
    rdy_in     = 1'b1;
    clear_in   = 1'b0;
    if_req_in  = 1'b0;
    if_addr_in = '0;
    ls_req_in  = 1'b0;
    ls_wr_in   = 1'b0;
    ls_size_in = 2'd0;
    ls_addr_in = '0;
    ls_data_in = '0;
    #2;
    do_reset();
    chk("idle_dout", {24'h0, mem_dout}, 32'h0);

    // IF word read of 0x1000.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("if_addr", mem_a, 32'h1000 + i);
    end
    step();
    chk("if_done_early", {31'h0, if_done_out}, 32'h0);
    chk("if_idle_a", mem_a, 32'h0);
    step();
    chk("if_done", {31'h0, if_done_out}, 32'h1);
    chk("if_data", if_data_out, 32'h0000_0513);
    if_req_in = 1'b0;
    step();
    chk("if_done_pulse", {31'h0, if_done_out}, 32'h0);
    chk("if_data_hold", if_data_out, 32'h0000_0513);

    // LS word write 0xDEADBEEF to 0x2000, bytes little-endian.
    ls_req_in = 1'b1; ls_wr_in = 1'b1; ls_size_in = 2'd2;
    ls_addr_in = 32'h2000; ls_data_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wexp;
      wexp = 32'hDEAD_BEEF >> (8 * i);
      step();
      chk("wr_addr", mem_a, 32'h2000 + i);
      chk("wr_en", {31'h0, mem_wr}, 32'h1);
      chk("wr_byte", {24'h0, mem_dout}, {24'h0, wexp[7:0]});
    end
    step();
    chk("wr_done", {31'h0, ls_done_out}, 32'h1);
    chk("wr_en_off", {31'h0, mem_wr}, 32'h0);
    ls_req_in = 1'b0; ls_wr_in = 1'b0;
    step();

    // Conflict right after reset: LS half read first, then IF.
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    ls_req_in = 1'b1; ls_size_in = 2'd1; ls_addr_in = 32'h3002;
    step();
    chk("c1_ls_a0", mem_a, 32'h3002);
    step();
    chk("c1_ls_a1", mem_a, 32'h3003);
    step();
    chk("c1_ls_done_early", {31'h0, ls_done_out}, 32'h0);
    step();
    chk("c1_ls_done", {31'h0, ls_done_out}, 32'h1);
    chk("c1_ls_data", ls_data_out, 32'h0000_1234);
    ls_req_in = 1'b0;
    step();
    chk("c1_if_granted", mem_a, 32'h1000);
    for (int i = 0; i < 5; i++) step();
    chk("c1_if_done", {31'h0, if_done_out}, 32'h1);
    chk("c1_if_data", if_data_out, 32'h0000_0513);
    if_req_in = 1'b0;
    step();

    // Second conflict goes to IF.
    if_req_in = 1'b1;
    ls_req_in = 1'b1;
    step();
    chk("c2_if_first", mem_a, 32'h1000);
    for (int i = 0; i < 5; i++) step();
    chk("c2_if_done", {31'h0, if_done_out}, 32'h1);
    if_req_in = 1'b0;
    step();
    chk("c2_ls_a0", mem_a, 32'h3002);
    for (int i = 0; i < 3; i++) step();
    chk("c2_ls_done", {31'h0, ls_done_out}, 32'h1);
    chk("c2_ls_data", ls_data_out, 32'h0000_1234);
    ls_req_in = 1'b0;
    step();

    // Clear during IF read aborts; following LS word read returns the written word.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    pulses = 0;
    step();
    step();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0; if_req_in = 1'b0;
    chk("clr_idle_a", mem_a, 32'h0);
    ls_req_in = 1'b1; ls_size_in = 2'd2; ls_addr_in = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if_done_out) pulses++;
    end
    chk("clr_no_if_done", 32'(pulses), 32'h0);
    chk("clr_ls_done", {31'h0, ls_done_out}, 32'h1);
    chk("clr_ls_data", ls_data_out, 32'hDEAD_BEEF);
    ls_req_in = 1'b0;
    step();

    // rdy_in low for three cycles mid IF read.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    step();
    chk("rdy_a0", mem_a, 32'h1000);
    rdy_in = 1'b0;
    step();
    chk("rdy_wr_off", {31'h0, mem_wr}, 32'h0);
    step();
    step();
    rdy_in = 1'b1;
    step();
    chk("rdy_reissue", mem_a, 32'h1001);
    step();
    chk("rdy_done_delayed", {31'h0, if_done_out}, 32'h0);
    step();
    chk("rdy_a3", mem_a, 32'h1003);
    step();
    step();
    chk("rdy_done", {31'h0, if_done_out}, 32'h1);
    chk("rdy_data", if_data_out, 32'h0000_0513);
    if_req_in = 1'b0;
    step();

    // IO byte read ignores clear_in.
    ls_req_in = 1'b1; ls_size_in = 2'd0; ls_addr_in = 32'h0003_0000;
    step();
    chk("io_addr", mem_a, 32'h0003_0000);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("io_single_issue", mem_a, 32'h0);
    step();
    chk("io_done", {31'h0, ls_done_out}, 32'h1);
    chk("io_data", ls_data_out, 32'h0000_005A);
    ls_req_in = 1'b0;
    step();

    // Size code 3 is a word; address wraps past 0xFFFFFFFF.
    ls_req_in = 1'b1; ls_size_in = 2'd3; ls_addr_in = 32'hFFFF_FFFE;
    step();
    step();
    chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
    step();
    chk("wrap_a2", mem_a, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("wrap_done", {31'h0, ls_done_out}, 32'h1);
    chk("wrap_data", ls_data_out, 32'h4433_2211);
    ls_req_in = 1'b0;
    step();

    // Reset mid-operation abandons the read without a done pulse.
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    step();
    step();
    rst_n_in = 1'b0;
    #1;
    chk("midrst_a", mem_a, 32'h0);
    chk("midrst_if_data", if_data_out, 32'h0);
    if_req_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_done_out) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
